// File: rtl/music_pkg.sv
// Shared definitions for the music note player blocks.
//   NOTE_W     width of a note code ([5:0] = octave*12 + note, 0 = rest)
//   REST_CODE  note code that keeps the gate closed while timing still runs
//   state_t    arbiter FSM states
package music_pkg;

  localparam int NOTE_W = 8;
  localparam logic [NOTE_W-1:0] REST_CODE = 8'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/music_tick_gen.sv
// Free-running duration tick prescaler, shared by the arbiter and the song sequencer.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous reset, active-high (counter -> 0)
//   tick  out  one-cycle pulse while the counter sits at TICK_DIV-1
module music_tick_gen
  import music_pkg::*;
#(
  parameter int TICK_DIV = 390625
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(TICK_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous, sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/music_arbiter.sv
// Round-robin scheduler sharing one tone generator between NUM_REQ sound sources.
// Each granted source plays its note for dur ticks, then a silent gap of
// GAP_TICKS ticks follows before the next grant.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous reset, active-high
//   req       in   [NUM_REQ]        level request per source, held until ack
//   note_in   in   [8*NUM_REQ]      per-source note code, slice i = [8*i+7:8*i]
//   dur_in    in   [DUR_W*NUM_REQ]  per-source duration in ticks (0 plays as 1)
//   stop      in   abort current note/gap and return to IDLE
//   ack       out  [NUM_REQ]        1-cycle pulse: request accepted, note/dur latched
//   done      out  [NUM_REQ]        1-cycle pulse: note finished its full duration
//   note_out  out  [8]              registered note code to the tone generator
//   note_on   out  generator gate
//   busy      out  high in any state other than IDLE
module music_arbiter
  import music_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int TICK_DIV  = 390625,
  parameter int GAP_TICKS = 1,
  parameter int DUR_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NOTE_W*NUM_REQ-1:0] note_in,
  input  logic [DUR_W*NUM_REQ-1:0] dur_in,
  input  logic                     stop,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_REQ-1:0]       done,
  output logic [NOTE_W-1:0]        note_out,
  output logic                     note_on,
  output logic                     busy
);

  localparam int RR_W  = $clog2(NUM_REQ);
  // Keep the gap counter at least one bit wide so GAP_TICKS=0 still elaborates.
  localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  state_t            state;
  logic [RR_W-1:0]   rr;
  logic [DUR_W-1:0]  remaining;
  logic [GAP_W-1:0]  gap_cnt;
  logic              tick;

  logic [RR_W:0]     pick;
  logic              grant_valid;
  logic [RR_W-1:0]   grant_idx;
  logic [NOTE_W-1:0] sel_note;
  logic [DUR_W-1:0]  sel_dur;

  // Round-robin search: first set request starting just above the last grant,
  // wrapping. Result is {found, index}. Scanning from the farthest candidate
  // down lets the nearest one overwrite and win.
  function automatic logic [RR_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [RR_W-1:0]    last);
    logic [RR_W:0] res;
    int idx;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (r[idx]) res = {1'b1, RR_W'(idx)};
    end
    return res;
  endfunction

  music_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // NOTE: every combinational output gets a value on every path, so no latch is inferred.
  always_comb begin
    pick        = rr_pick(req, rr);
    grant_valid = pick[RR_W];
    grant_idx   = pick[RR_W-1:0];
    sel_note    = note_in[NOTE_W*grant_idx +: NOTE_W];
    sel_dur     = dur_in[DUR_W*grant_idx +: DUR_W];
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr        <= RR_W'(NUM_REQ - 1);
      remaining <= '0;
      gap_cnt   <= '0;
      ack       <= '0;
      done      <= '0;
      note_out  <= '0;
      note_on   <= 1'b0;
    end else begin
      // ack/done are pulses: cleared every cycle unless set below.
      ack  <= '0;
      done <= '0;
      if (stop) begin
        // Abort wins over any same-cycle grant or tick; rr is left as is.
        state   <= IDLE;
        note_on <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (grant_valid) begin
              state          <= PLAY;
              rr             <= grant_idx;
              ack[grant_idx] <= 1'b1;
              note_out       <= sel_note;
              note_on        <= (sel_note != REST_CODE);
              remaining      <= (sel_dur == '0) ? DUR_W'(1) : sel_dur;
            end
          end
          PLAY: begin
            if (tick) begin
              if (remaining == DUR_W'(1)) begin
                done[rr] <= 1'b1;
                note_on  <= 1'b0;
                if (GAP_TICKS > 0) begin
                  state   <= GAP;
                  gap_cnt <= GAP_W'(GAP_TICKS);
                end else begin
                  state <= IDLE;
                end
              end else begin
                remaining <= remaining - DUR_W'(1);
              end
            end
          end
          GAP: begin
            note_on <= 1'b0;
            if (tick) begin
              if (gap_cnt <= GAP_W'(1)) state <= IDLE;
              else gap_cnt <= gap_cnt - GAP_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_music_arbiter.sv
// Self-checking bench for music_arbiter (NUM_REQ=4, TICK_DIV=4, GAP_TICKS=1, DUR_W=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_music_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int TICK_DIV  = 4;
  localparam int GAP_TICKS = 1;
  localparam int DUR_W     = 8;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_REQ-1:0]         req;
  logic [8*NUM_REQ-1:0]       note_in;
  logic [DUR_W*NUM_REQ-1:0]   dur_in;
  logic                       stop;
  logic [NUM_REQ-1:0]         ack;
  logic [NUM_REQ-1:0]         done;
  logic [7:0]                 note_out;
  logic                       note_on;
  logic                       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int model_rr = NUM_REQ - 1;  // last granted source, as the bench tracks it

  music_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .TICK_DIV (TICK_DIV),
    .GAP_TICKS(GAP_TICKS),
    .DUR_W    (DUR_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .note_in (note_in),
    .dur_in  (dur_in),
    .stop    (stop),
    .ack     (ack),
    .done    (done),
    .note_out(note_out),
    .note_on (note_on),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int next_grant(input logic [NUM_REQ-1:0] pend, input int last);
    for (int k = 1; k <= NUM_REQ; k++)
      if (pend[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    return -1;
  endfunction

  // Waits for the grant of src, follows the note to its done pulse and through the gap.
  // Expected note length in PLAY: (d-1)*TICK_DIV+1 .. d*TICK_DIV cycles, d = max(dur,1).
  // Busy must stay high for the gap tick window and drop exactly TICK_DIV cycles after done.
  task automatic run_note(input int src, input logic [7:0] nt, input logic [7:0] du,
                          input bit reraise);
    int  cyc;
    int  play;
    int  d;
    bit  ok;
    logic [NUM_REQ-1:0] exp_ack;
    exp_ack = NUM_REQ'(1 << src);
    d   = (du == 8'd0) ? 1 : int'(du);
    cyc = 0;
    while (ack == '0 && cyc < 40) begin
      step();
      cyc++;
    end
    check("ack_src", 32'(ack), 32'(exp_ack));
    check("note_out_at_ack", 32'(note_out), 32'(nt));
    check("note_on_at_ack", 32'(note_on), 32'(nt != 8'd0));
    check("busy_at_ack", 32'(busy), 32'd1);
    model_rr = src;
    req[src] = 1'b0;
    ok   = 1'b1;
    play = 0;
    while (done == '0 && play < d * TICK_DIV + 4) begin
      if (note_on !== (nt != 8'd0) || note_out !== nt || busy !== 1'b1) ok = 1'b0;
      if (ack !== ((play == 0) ? exp_ack : '0)) ok = 1'b0;
      play++;
      step();
      if (play == 1) req[src] = reraise;
    end
    check("play_outputs_steady", 32'(ok), 32'd1);
    check("done_src", 32'(done), 32'(exp_ack));
    check("play_len_in_range",
          32'(play >= (d - 1) * TICK_DIV + 1 && play <= d * TICK_DIV), 32'd1);
    ok = 1'b1;
    for (int k = 0; k < GAP_TICKS * TICK_DIV; k++) begin
      if (busy !== 1'b1 || note_on !== 1'b0 || ack !== '0) ok = 1'b0;
      if (k > 0 && done !== '0) ok = 1'b0;
      step();
    end
    check("gap_busy_silent", 32'(ok), 32'd1);
    check("busy_low_after_gap", 32'(busy), 32'd0);
  endtask

  initial begin
    int  cyc;
    bit  ok;
    logic [NUM_REQ-1:0] pend;
    logic [7:0] nts [NUM_REQ];
    logic [7:0] dus [NUM_REQ];
    int  g;

    // 1. Reset held with all requests up
    rst  = 1'b1;
    stop = 1'b0;
    req  = 4'hF;
    for (int i = 0; i < NUM_REQ; i++) begin
      note_in[8*i +: 8]       = 8'h10 + 8'(i);
      dur_in[DUR_W*i +: DUR_W] = 8'd1;
    end
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_note_on", 32'(note_on), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    check("rst_note_out", 32'(note_out), 32'd0);
    rst = 1'b0;

    // 3. Round robin with req held: order 0,1,2,3,0 (source 0 re-raised)
    run_note(0, 8'h10, 8'd1, 1'b1);
    run_note(1, 8'h11, 8'd1, 1'b0);
    run_note(2, 8'h12, 8'd1, 1'b0);
    run_note(3, 8'h13, 8'd1, 1'b0);
    run_note(0, 8'h10, 8'd1, 1'b0);

    // 2. Single note on source 2
    note_in[23:16] = 8'h15;
    dur_in[23:16]  = 8'd3;
    req = 4'b0100;
    run_note(2, 8'h15, 8'd3, 1'b0);

    // 4. Rest note, then zero duration
    note_in[15:8] = 8'h00;
    dur_in[15:8]  = 8'd2;
    req = 4'b0010;
    run_note(1, 8'h00, 8'd2, 1'b0);
    note_in[15:8] = 8'h2C;
    dur_in[15:8]  = 8'd0;
    req = 4'b0010;
    run_note(1, 8'h2C, 8'd0, 1'b0);

    // 5. stop mid-PLAY, pending request served right after
    note_in[7:0] = 8'h20;
    dur_in[7:0]  = 8'd5;
    req = 4'b0001;
    cyc = 0;
    while (ack == '0 && cyc < 40) begin
      step();
      cyc++;
    end
    check("stop_pre_ack", 32'(ack), 32'd1);
    req[0] = 1'b0;
    note_in[15:8] = 8'h31;
    dur_in[15:8]  = 8'd2;
    req[1] = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (done !== '0 || note_on !== 1'b1 || ack !== '0) ok = 1'b0;
    end
    check("stop_pre_playing", 32'(ok), 32'd1);
    stop = 1'b1;
    step();
    check("stop_note_on", 32'(note_on), 32'd0);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_no_done", 32'(done), 32'd0);
    check("stop_no_ack", 32'(ack), 32'd0);
    model_rr = 0;
    stop = 1'b0;
    step();
    check("stop_next_ack", 32'(ack), 32'd2);
    run_note(1, 8'h31, 8'd2, 1'b0);

    // 6. stop blocks a same-cycle grant; latched note immune to input changes
    note_in[31:24] = 8'h27;
    dur_in[31:24]  = 8'd2;
    stop = 1'b1;
    req  = 4'b1000;
    step();
    check("stop_idle_no_ack", 32'(ack), 32'd0);
    check("stop_idle_busy", 32'(busy), 32'd0);
    step();
    check("stop_idle_no_ack2", 32'(ack), 32'd0);
    stop = 1'b0;
    step();
    check("release_ack3", 32'(ack), 32'd8);
    note_in[31:24] = 8'h3A;
    dur_in[31:24]  = 8'd9;
    run_note(3, 8'h27, 8'd2, 1'b0);

    // Random phase: random pending sets served in round-robin order
    for (int it = 0; it < 16; it++) begin
      pend = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      for (int i = 0; i < NUM_REQ; i++) begin
        nts[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 63));
        dus[i] = 8'($urandom_range(0, 3));
        note_in[8*i +: 8]        = nts[i];
        dur_in[DUR_W*i +: DUR_W] = dus[i];
      end
      for (int w = $urandom_range(0, 3); w > 0; w--) step();
      req = pend;
      while (pend != '0) begin
        g = next_grant(pend, model_rr);
        run_note(g, nts[g], dus[g], 1'b0);
        pend[g] = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
